// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// almost-full/almost-empty thresholds. Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow.
module sync_fifo #(
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_SIZE  = 4,
   parameter int AFULL_LVL  = 12,
   parameter int AEMPTY_LVL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_inc,
   input  logic [DATA_SIZE-1:0] wr_data,
   output logic                 wr_full,
   input  logic                 rd_inc,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 rd_empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADDR_SIZE:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   output logic                 overflow,
   output logic                 underflow
`endif
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] DEPTH_C  = DEPTH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] AFULL_C  = AFULL_LVL[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0] AEMPTY_C = AEMPTY_LVL[ADDR_SIZE:0];

   generate
      if (AEMPTY_LVL < 0 || AEMPTY_LVL >= AFULL_LVL || AFULL_LVL > DEPTH) begin : g_bad_lvl
         $error("sync_fifo: thresholds must satisfy 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH");
      end
   endgenerate

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE:0]   wr_ptr;
   logic [ADDR_SIZE:0]   rd_ptr;
   logic                 wr_acc;
   logic                 rd_acc;

   // The extra pointer MSB makes the difference an exact occupancy, 0..DEPTH.
   assign count        = wr_ptr - rd_ptr;
   assign wr_full      = (count == DEPTH_C);
   assign rd_empty     = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   assign wr_acc = wr_inc && !wr_full;
   assign rd_acc = rd_inc && !rd_empty;

   always_ff @(posedge clk) begin
      if (!rst && wr_acc)
         mem[wr_ptr[ADDR_SIZE-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr[ADDR_SIZE-1:0]];
         end
         rd_valid <= rd_acc;
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // A write against a full FIFO is only an error if no read frees a slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_inc && wr_full && !rd_acc)
            overflow <= 1'b1;
         if (rd_inc && rd_empty)
            underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: table of directed vectors plus a queue model and read
// scoreboard, then random wrap traffic and a reset-under-load sequence.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_inc;
   logic [7:0] wr_data;
   logic       wr_full;
   logic       rd_inc;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   always #5 clk = ~clk;

   sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .AFULL_LVL(12), .AEMPTY_LVL(4)) dut (
      .clk(clk), .rst(rst),
      .wr_inc(wr_inc), .wr_data(wr_data), .wr_full(wr_full),
      .rd_inc(rd_inc), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   typedef struct {
      bit         r;
      bit         w;
      logic [7:0] d;
      bit         rd;
      int         cnt;
      bit         vld;
      bit         ovf;
      bit         unf;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_rd;
   bit         m_vld, m_ovf, m_unf;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input bit r, input bit w, input logic [7:0] d, input bit rd,
                      input int cnt, input bit vld, input bit ovf, input bit unf);
      vq.push_back('{r, w, d, rd, cnt, vld, ovf, unf});
   endtask

   // One clock of stimulus; the queue model decides acceptance from pre-edge occupancy.
   task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd);
      int n;
      bit full_m, empty_m, wacc, racc;
      rst = r; wr_inc = w; wr_data = d; rd_inc = rd;
      n = mq.size();
      full_m  = (n == 16);
      empty_m = (n == 0);
      wacc = w && !full_m;
      racc = rd && !empty_m;
      @(posedge clk);
      if (r) begin
         mq.delete(); exp_q.delete();
         m_rd = 8'h00; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         m_vld = racc;
         if (racc) begin
            m_rd = mq.pop_front();
            exp_q.push_back(m_rd);
         end
         if (wacc) mq.push_back(d);
         if (w && full_m && !racc) m_ovf = 1'b1;
         if (rd && empty_m) m_unf = 1'b1;
      end
      #1;
      rst = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0;
      n = mq.size();
      chk("count",        32'(count),        32'(n));
      chk("wr_full",      32'(wr_full),      32'(n == 16));
      chk("rd_empty",     32'(rd_empty),     32'(n == 0));
      chk("almost_full",  32'(almost_full),  32'(n >= 12));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
      chk("rd_valid",     32'(rd_valid),     32'(m_vld));
      chk("rd_data_hold", 32'(rd_data),      32'(m_rd));
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_pop: rd_valid with no pending read, rd_data %0h", rd_data);
         end else begin
            chk("sb_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
      end else begin
         exp_q.delete();
      end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`endif
   endtask

   initial begin
      vec_t v;
      int   tgt;
      rst = 1'b1; wr_inc = 1'b0; wr_data = '0; rd_inc = 1'b0;

      // fill, overfill, drain, overdrain
      add(1, 0, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) add(0, 1, 8'(i), 0, i + 1, 0, 0, 0);
      add(0, 1, 8'hAA, 0, 16, 0, 1, 0);
      for (int i = 0; i < 16; i++) add(0, 0, 8'h00, 1, 15 - i, 1, 1, 0);
      add(0, 0, 8'h00, 1, 0, 0, 1, 1);
      add(1, 0, 8'h00, 0, 0, 0, 0, 0);
      // threshold crossings up and down
      for (int i = 0; i < 12; i++) add(0, 1, 8'(8'h30 + i), 0, i + 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) add(0, 0, 8'h00, 1, 11 - i, 1, 0, 0);
      // simultaneous read+write at mid, full and empty
      for (int i = 0; i < 5; i++) add(0, 1, 8'(8'h50 + i), 0, i + 1, 0, 0, 0);
      add(0, 1, 8'h60, 1, 5, 1, 0, 0);
      add(0, 1, 8'h61, 1, 5, 1, 0, 0);
      for (int i = 0; i < 11; i++) add(0, 1, 8'(8'h70 + i), 0, 6 + i, 0, 0, 0);
      add(0, 1, 8'h90, 1, 15, 1, 0, 0);
      for (int i = 0; i < 15; i++) add(0, 0, 8'h00, 1, 14 - i, 1, 0, 0);
      add(0, 1, 8'hA0, 1, 1, 0, 0, 1);
      add(0, 0, 8'h00, 1, 0, 1, 0, 1);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         step(v.r, v.w, v.d, v.rd);
         chk("tbl_count",  32'(count),        32'(v.cnt));
         chk("tbl_valid",  32'(rd_valid),     32'(v.vld));
         chk("tbl_afull",  32'(almost_full),  32'(v.cnt >= 12));
         chk("tbl_aempty", 32'(almost_empty), 32'(v.cnt <= 4));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
         chk("tbl_ovf", 32'(overflow),  32'(v.ovf));
         chk("tbl_unf", 32'(underflow), 32'(v.unf));
`endif
      end

      // random occupancy traffic, enough to wrap both pointers many times
      for (int it = 0; it < 40; it++) begin
         tgt = $urandom_range(0, 16);
         while (mq.size() < tgt) step(0, 1, 8'($urandom), 0);
         step(0, 1, 8'($urandom), 1);
         tgt = $urandom_range(0, mq.size());
         while (mq.size() > tgt) step(0, 0, 8'h00, 1);
      end

      // reset under load overrides same-cycle read and write
      step(1, 0, 8'h00, 0);
      for (int i = 1; i <= 10; i++) step(0, 1, 8'(8'h40 + i), 0);
      step(0, 0, 8'h00, 1);
      chk("pre_rst_count", 32'(count),   32'd9);
      chk("pre_rst_data",  32'(rd_data), 32'h41);
      step(1, 1, 8'h33, 1);
      chk("rst_count", 32'(count),    32'd0);
      chk("rst_empty", 32'(rd_empty), 32'd1);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data",  32'(rd_data),  32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("rst_ovf", 32'(overflow),  32'd0);
      chk("rst_unf", 32'(underflow), 32'd0);
`endif
      step(0, 0, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
